serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial two's-complement adder; operands are processed LSB-first, one bit per clock.
- Each bit goes through a full-adder cell built from the hXor/hAnd/hOr gate primitives, with the carry held in a flip-flop.
- Sits downstream of the XOR gate layer in the ALU datapath.
- Provides a start/busy/done handshake so a controller can issue additions and collect WIDTH-bit results with carry and overflow flags.

Parameters:
- WIDTH, 16: operand/result width in bits; Hack word size; legal range 2..32.
- CNT_W, $clog2(WIDTH): width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an addition; sampled only when not busy.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: result registers just updated.
- sum  output  WIDTH  result register (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state (rst_n low, asynchronous): state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0. Internal operand shift registers, carry flop and counter are all cleared.
- State machine, IDLE -> RUN -> DONE:
  - IDLE: busy=0. An edge with start=1 loads a_sh<=a, b_sh<=b, c<=cin, cnt<=0, acc<=0, then goes to RUN.
  - RUN: busy=1. Each edge computes s = a_sh[0]^b_sh[0]^c and c_next = maj(a_sh[0], b_sh[0], c).
    - a_sh and b_sh shift right by one; acc shifts right with s entering at the MSB; c<=c_next; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1:
      - sum <= final acc (including this bit).
      - cout <= c_next.
      - ovf <= c ^ c_next, where c is the carry into the MSB.
      - done<=1; next state is DONE.
  - DONE: busy=0, done=1 for exactly this cycle. The next edge returns to IDLE, or, if start=1, accepts a new operation exactly as IDLE does (back-to-back issue).
- Latency: the start-accept edge is E0. busy is high after E0 through E_WIDTH-1. Results and done are visible after E_WIDTH, so the start-to-done latency is WIDTH+1 edges. Peak throughput is one addition per WIDTH+1 cycles.
- start while busy=1 is ignored: no restart, and captured operands are unaffected.
- sum, cout and ovf change only on the completion edge. They hold their values through IDLE and through the next operation until its completion.
- a, b and cin may change freely after the accept edge.
- Counter wrap: cnt never exceeds WIDTH-1. It is reloaded to 0 on every accept.
- Reset mid-RUN: the operation is aborted immediately, all outputs go to their reset values, and no done pulse is issued.
- A start asserted while rst_n is low is ignored. The first start seen after rst_n deasserts is accepted normally.

Decomposition:
- Shared header serial_defs.vh, guarded by an include guard, holds:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
  - the default word width 16.
- One sub-module, full_adder_cell (inputs a, b, cin; outputs s, cout). It is built structurally from hXor, hAnd and hOr: s = a^b^cin, cout = (a&b)|(cin&(a^b)). It is instantiated once and shared across bit-times.
- FSM, counter and shift registers are behavioural in serial_adder.

Test Plan:
- a=0x0003, b=0x0005, cin=0, start pulse -> done after 17 edges; sum=0x0008, cout=0, ovf=0; busy high for exactly 16 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Repeat with a=0xFFFF, b=0x0000, cin=1 -> same result.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Start held high continuously with operands changed after the first accept -> second operation accepted only in the DONE cycle. Results are 0x1234+0x1111=0x2345, then 0x0F0F+0x00F1=0x1000, with done pulses 17 edges apart.
- Assert rst_n=0 at bit 7 of 0xAAAA+0x5555 -> outputs immediately 0, no done pulse. After release, a fresh start with 0xAAAA+0x5555 yields sum=0xFFFF, cout=0, ovf=0.
- Random sweep of 1000 operand/cin triples against a reference model, a+b+cin, checking sum, cout and signed overflow; also WIDTH=4 exhaustive (all 512 cases).

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the bit-serial adder.
//   DEFAULT_WIDTH : default word width (Hack word size).
//   state_t       : FSM state encoding; 2'd3 is illegal and recovers to IDLE.
//   hXor/hAnd/hOr : single-bit gate primitives used to build the adder cell.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic hXor(input logic x, input logic y);
        return x ^ y;
    endfunction

    function automatic logic hAnd(input logic x, input logic y);
        return x & y;
    endfunction

    function automatic logic hOr(input logic x, input logic y);
        return x | y;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit full adder built from the gate primitives.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit      = a ^ b ^ cin
//   cout  : carry out    = (a & b) | (cin & (a ^ b))
module full_adder_cell
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;  // propagate

    assign p    = hXor(a, b);
    assign s    = hXor(p, cin);
    assign cout = hOr(hAnd(a, b), hAnd(cin, p));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder, LSB first, one bit/clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request an addition (sampled only when not busy)
//   a, b, cin    : operands and carry-in, captured on the accept edge
//   busy         : high while bits are processed (WIDTH cycles)
//   done         : one-cycle pulse when sum/cout/ovf were just updated
//   sum          : (a + b + cin) mod 2^WIDTH
//   cout         : carry out of the MSB
//   ovf          : signed overflow (carry into MSB ^ carry out of MSB)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic             c_q;
    logic [CNT_W-1:0] cnt;
    logic             s_bit, c_next;
    logic             last, accept;

    // Single adder cell reused every bit-time.
    full_adder_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c_q),
        .s    (s_bit),
        .cout (c_next)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                // Back-to-back issue: DONE accepts exactly like IDLE.
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            acc  <= '0;
            c_q  <= cin;
            cnt  <= '0;
        end else if (state_q == S_RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= {s_bit, acc[WIDTH-1:1]};
            c_q  <= c_next;
            // Hold cnt inside 0..WIDTH-1 even for non-power-of-two widths.
            cnt  <= last ? '0 : cnt + 1'b1;
            if (last) begin
                sum  <= {s_bit, acc[WIDTH-1:1]};
                cout <= c_next;
                ovf  <= c_q ^ c_next;  // c_q is the carry into the MSB here
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        busy16, done16, cout16, ovf16;

    logic        start4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0, sum4;
    logic        busy4, done4, cout4, ovf4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow = signed result out of range.
    task automatic model(input int w, input int ta, input int tb_, input int tc,
                         output int es, output int ec, output int eo);
        int full, sa, sb, ss, half;
        half = 1 << (w - 1);
        full = ta + tb_ + tc;
        es   = full % (1 << w);
        ec   = full >> w;
        sa   = (ta >= half) ? ta - (1 << w) : ta;
        sb   = (tb_ >= half) ? tb_ - (1 << w) : tb_;
        ss   = sa + sb + tc;
        eo   = (ss >= half || ss < -half) ? 1 : 0;
    endtask

    // Issue one 16-bit op, check latency, busy length, result and done pulse width.
    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input string tag);
        int edges, busy_cnt, es, ec, eo;
        model(16, int'(ta), int'(tb_), int'(tc), es, ec, eo);
        @(negedge clk);
        a16 = ta; b16 = tb_; cin16 = tc; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        a16 = $urandom; b16 = $urandom; cin16 = $urandom;  // free to change now
        edges = 1; busy_cnt = 0;
        while (!done16 && edges < 40) begin
            if (busy16) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        check(32'(done16), 32'd1, {tag, " done"});
        check(32'(edges), 32'd17, {tag, " latency"});
        check(32'(busy_cnt), 32'd16, {tag, " busy_len"});
        check(32'(sum16), 32'(es), {tag, " sum"});
        check(32'(cout16), 32'(ec), {tag, " cout"});
        check(32'(ovf16), 32'(eo), {tag, " ovf"});
        @(negedge clk);
        check(32'(done16), 32'd0, {tag, " done_pulse"});
        check(32'(sum16), 32'(es), {tag, " sum_hold"});
    endtask

    task automatic op4(input int ta, input int tb_, input int tc);
        int edges, es, ec, eo;
        model(4, ta, tb_, tc, es, ec, eo);
        @(negedge clk);
        a4 = 4'(ta); b4 = 4'(tb_); cin4 = tc[0]; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        edges = 1;
        while (!done4 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check(32'(edges), 32'd5, "w4 latency");
        check({cout4, ovf4, sum4}, 32'({ec[0], eo[0], es[3:0]}),
              $sformatf("w4 %0d+%0d+%0d", ta, tb_, tc));
    endtask

    initial begin
        int edges, e1, e2;

        // Reset state, with start asserted while in reset (must be ignored).
        start16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222;
        repeat (3) @(negedge clk);
        check({busy16, done16, cout16, ovf16, sum16}, 32'd0, "reset_outputs");
        start16 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check(32'(busy16), 32'd0, "idle_after_reset");

        // Directed cases.
        op16(16'h0003, 16'h0005, 1'b0, "3+5");
        op16(16'hFFFF, 16'h0001, 1'b0, "FFFF+1");
        op16(16'hFFFF, 16'h0000, 1'b1, "FFFF+0+c");
        op16(16'h7FFF, 16'h0001, 1'b0, "7FFF+1");
        op16(16'h8000, 16'h8000, 1'b0, "8000+8000");

        // Back-to-back with start held high.
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        a16 = 16'h0F0F; b16 = 16'h00F1;
        edges = 1;
        while (!done16 && edges < 40) begin @(negedge clk); edges++; end
        e1 = edges;
        check(32'(sum16), 32'h2345, "b2b first_sum");
        while (edges < 80) begin
            @(negedge clk); edges++;
            if (done16) break;
        end
        start16 = 1'b0;
        e2 = edges;
        check(32'(done16), 32'd1, "b2b second_done");
        check(32'(e2 - e1), 32'd17, "b2b done_spacing");
        check(32'(sum16), 32'h1000, "b2b second_sum");
        @(negedge clk);

        // Reset mid-run at bit 7; start held during reset must be ignored.
        @(negedge clk);
        a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        start16 = 1'b1;
        #1;
        check({busy16, done16, cout16, ovf16, sum16}, 32'd0, "midrun_reset");
        repeat (2) @(negedge clk);
        start16 = 1'b0;
        rst_n = 1'b1;
        e1 = 0;
        repeat (20) begin
            @(negedge clk);
            if (done16 || busy16) e1++;
        end
        check(32'(e1), 32'd0, "no_done_after_abort");
        op16(16'hAAAA, 16'h5555, 1'b0, "AAAA+5555");

        // Random sweep.
        for (int i = 0; i < 1000; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom), "rand");

        // Exhaustive 4-bit.
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    op4(x, y, c);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
